// File: rtl/rat_add_arb.sv
// Round-robin arbiter sharing one rational-addition datapath (s = l + r) among NREQ requesters.
// Equal denominators finish in one step, unequal ones cross-multiply in two.
module rat_add_arb #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDW   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_l_num,
    input  logic [NREQ*WIDTH-1:0]   req_l_den,
    input  logic [NREQ*WIDTH-1:0]   req_r_num,
    input  logic [NREQ*WIDTH-1:0]   req_r_den,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [IDW-1:0]          resp_id,
    output logic [WIDTH-1:0]        resp_num,
    output logic [WIDTH-1:0]        resp_den,
    output logic                    resp_err,
    output logic                    busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CALC1 = 2'd1;
    localparam logic [1:0] CALC2 = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam int unsigned XW = IDW + 1;
    localparam logic [XW-1:0] NREQ_X = XW'(NREQ);

    logic [1:0]          state;
    logic [1:0]          state_nxt;
    logic [IDW-1:0]      ptr;
    logic [IDW-1:0]      ptr_nxt;
    logic [IDW-1:0]      gnt;
    logic                gnt_found;
    logic [2*NREQ-1:0]   rot;
    logic [XW-1:0]       off;
    logic [XW-1:0]       gsum;
    logic [XW-1:0]       psum;
    logic                accept;

    logic [WIDTH-1:0]    l_num, l_den, r_num, r_den;
    logic [WIDTH-1:0]    t1, t2, t3;
    logic [WIDTH-1:0]    sel_l_num, sel_l_den, sel_r_num, sel_r_den;

    // Rotate requests so bit 0 is the pointer position, then take the first set bit.
    always_comb begin
        rot       = {req_valid, req_valid} >> ptr;
        gnt_found = 1'b0;
        off       = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!gnt_found && rot[k]) begin
                gnt_found = 1'b1;
                off       = XW'(k);
            end
        end
        gsum = {1'b0, ptr} + off;
        if (gsum >= NREQ_X) begin
            gsum = gsum - NREQ_X;
        end
        gnt  = gsum[IDW-1:0];
        psum = gsum + XW'(1);
        if (psum >= NREQ_X) begin
            psum = psum - NREQ_X;
        end
        ptr_nxt = psum[IDW-1:0];
    end

    // Operand select for the granted requester.
    always_comb begin
        sel_l_num = '0;
        sel_l_den = '0;
        sel_r_num = '0;
        sel_r_den = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt == IDW'(i)) begin
                sel_l_num = req_l_num[i*WIDTH +: WIDTH];
                sel_l_den = req_l_den[i*WIDTH +: WIDTH];
                sel_r_num = req_r_num[i*WIDTH +: WIDTH];
                sel_r_den = req_r_den[i*WIDTH +: WIDTH];
            end
        end
    end

    assign accept = (state == IDLE) && gnt_found;

    always_comb begin
        req_ready = '0;
        if (accept && !rst) begin
            req_ready = NREQ'(1) << gnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = CALC1;
                end
            end
            CALC1: begin
                if ((l_den == '0) || (r_den == '0) || (l_den == r_den)) begin
                    state_nxt = RESP;
                end else begin
                    state_nxt = CALC2;
                end
            end
            CALC2: state_nxt = RESP;
            RESP: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, arithmetic steps and the held response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            l_num    <= '0;
            l_den    <= '0;
            r_num    <= '0;
            r_den    <= '0;
            t1       <= '0;
            t2       <= '0;
            t3       <= '0;
            resp_id  <= '0;
            resp_num <= '0;
            resp_den <= '0;
            resp_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        l_num   <= sel_l_num;
                        l_den   <= sel_l_den;
                        r_num   <= sel_r_num;
                        r_den   <= sel_r_den;
                        resp_id <= gnt;
                        ptr     <= ptr_nxt;
                    end
                end
                CALC1: begin
                    if ((l_den == '0) || (r_den == '0)) begin
                        resp_num <= '0;
                        resp_den <= '0;
                        resp_err <= 1'b1;
                    end else if (l_den == r_den) begin
                        resp_num <= l_num + r_num;
                        resp_den <= l_den;
                        resp_err <= 1'b0;
                    end else begin
                        t1 <= l_num * r_den;
                        t2 <= r_num * l_den;
                        t3 <= l_den * r_den;
                    end
                end
                CALC2: begin
                    resp_num <= t1 + t2;
                    resp_den <= t3;
                    resp_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign resp_valid = (state == RESP);
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_rat_add_arb.sv
// Bench for rat_add_arb: directed scenarios plus randomized operations checked against
// an arithmetic model of rational addition and a round-robin grant model.
module tb_rat_add_arb;

    localparam int unsigned W   = 8;
    localparam int unsigned N   = 4;
    localparam int unsigned IDW = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0]       req_valid;
    logic [N-1:0]       req_ready;
    logic [N*W-1:0]     req_l_num, req_l_den, req_r_num, req_r_den;
    logic               resp_valid;
    logic               resp_ready;
    logic [IDW-1:0]     resp_id;
    logic [W-1:0]       resp_num;
    logic [W-1:0]       resp_den;
    logic               resp_err;
    logic               busy;

    int tests = 0;
    int fails = 0;
    int mptr  = 0;

    always #5 clk = ~clk;

    rat_add_arb #(.WIDTH(W), .NREQ(N), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_l_num  (req_l_num),
        .req_l_den  (req_l_den),
        .req_r_num  (req_r_num),
        .req_r_den  (req_r_den),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_num   (resp_num),
        .resp_den   (resp_den),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int i, input logic [W-1:0] ln, input logic [W-1:0] ld,
                           input logic [W-1:0] rn, input logic [W-1:0] rd);
        req_l_num[i*W +: W] = ln;
        req_l_den[i*W +: W] = ld;
        req_r_num[i*W +: W] = rn;
        req_r_den[i*W +: W] = rd;
    endtask

    // First requester with valid set, scanning from the model pointer.
    function automatic int pick(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++) begin
            if (m[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // Rational sum l + r modulo 2^W, with zero-denominator error and step count.
    task automatic model(input int ln, input int ld, input int rn, input int rd,
                         output int n, output int d, output int e, output int lat);
        if (ld == 0 || rd == 0) begin
            n = 0; d = 0; e = 1; lat = 1;
        end else if (ld == rd) begin
            n = (ln + rn) % 256; d = ld; e = 0; lat = 1;
        end else begin
            n = (ln * rd + rn * ld) % 256; d = (ld * rd) % 256; e = 0; lat = 2;
        end
    endtask

    task automatic run_op(input logic [N-1:0] mask, input int hold);
        int g, en, ed, ee, elat, lat;
        req_valid = mask;
        #1;
        g = pick(mask, mptr);
        check("grant_onehot", 64'(req_ready), 64'(N'(1) << g));
        model(int'(req_l_num[g*W +: W]), int'(req_l_den[g*W +: W]),
              int'(req_r_num[g*W +: W]), int'(req_r_den[g*W +: W]), en, ed, ee, elat);
        @(posedge clk);
        #1;
        mptr = (g + 1) % N;
        set_ops(g, W'($urandom), W'($urandom), W'($urandom), W'($urandom));
        check("ready_low_busy", 64'(req_ready), 64'(0));
        check("busy_calc", 64'(busy), 64'(1));
        lat = 0;
        while (resp_valid !== 1'b1 && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(elat));
        check("resp_id", 64'(resp_id), 64'(g));
        check("resp_num", 64'(resp_num), 64'(en));
        check("resp_den", 64'(resp_den), 64'(ed));
        check("resp_err", 64'(resp_err), 64'(ee));
        repeat (hold) begin
            @(posedge clk);
            #1;
            check("hold_valid", 64'(resp_valid), 64'(1));
            check("hold_num", 64'(resp_num), 64'(en));
            check("hold_den", 64'(resp_den), 64'(ed));
            check("hold_ready", 64'(req_ready), 64'(0));
            check("hold_busy", 64'(busy), 64'(1));
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check("valid_drop", 64'(resp_valid), 64'(0));
        check("busy_drop", 64'(busy), 64'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '1;
        @(posedge clk);
        #1;
        check("rst_ready", 64'(req_ready), 64'(0));
        check("rst_valid", 64'(resp_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        req_valid = '0;
        rst = 1'b0;
        mptr = 0;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        resp_ready = 1'b0;
        req_l_num = '0; req_l_den = '0; req_r_num = '0; req_r_den = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_id", 64'(resp_id), 64'(0));
        check("reset_num", 64'(resp_num), 64'(0));
        check("reset_den", 64'(resp_den), 64'(0));
        check("reset_err", 64'(resp_err), 64'(0));
        do_reset();

        // Reset while the cross-multiply path is in flight.
        set_ops(0, 8'd1, 8'd2, 8'd1, 8'd3);
        req_valid = 4'b0001;
        @(posedge clk);
        #1;
        req_valid = '0;
        @(posedge clk);
        #1;
        check("mid_busy", 64'(busy), 64'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mptr = 0;
        check("abort_busy", 64'(busy), 64'(0));
        repeat (3) begin
            @(posedge clk);
            #1;
            check("abort_no_resp", 64'(resp_valid), 64'(0));
        end
        set_ops(2, 8'd1, 8'd4, 8'd1, 8'd4);
        run_op(4'b0100, 0);

        set_ops(1, 8'd3, 8'd8, 8'd4, 8'd8);
        run_op(4'b0010, 0);
        set_ops(0, 8'd1, 8'd2, 8'd1, 8'd3);
        run_op(4'b0001, 4);
        set_ops(3, 8'd5, 8'd0, 8'd1, 8'd4);
        run_op(4'b1000, 0);
        set_ops(0, 8'd200, 8'd3, 8'd100, 8'd3);
        run_op(4'b0001, 1);
        set_ops(1, 8'd16, 8'd17, 8'd1, 8'd16);
        run_op(4'b0010, 0);

        // All requesters pending from a fresh pointer: grants rotate 0,1,2,3,0.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < N; i++) set_ops(i, 8'd1, 8'd1, 8'd1, 8'd1);
            check("rr_model_order", 64'(pick(4'b1111, mptr)), 64'(k % N));
            run_op(4'b1111, 0);
        end

        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) begin
                set_ops(i, W'($urandom), W'($urandom_range(0, 5)),
                        W'($urandom), W'($urandom_range(0, 5)));
            end
            run_op(N'($urandom_range(1, 15)), int'($urandom_range(0, 2)));
        end

        req_valid = '0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rat_add_arb.md
Name: rat_add_arb

Overview:
- Round-robin arbiter and sequencer that shares one rational-addition datapath (s = l + r over num/den pairs) among NREQ requesters.
- Each requester presents an operand pair with a valid/ready handshake. The block grants one requester, runs the equal-denominator path (1 step) or the cross-multiply path (2 steps), then returns the sum tagged with the requester id.
- Sits between the rational-arithmetic clients and the result consumer; one operation in flight at a time.

Parameters:
- WIDTH, 32, bit width of every numerator/denominator field.
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of requester id; must satisfy 2^IDW >= NREQ.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; at most one bit high.
- req_l_num  input  NREQ*WIDTH  left numerators; requester i at bits [i*WIDTH +: WIDTH].
- req_l_den  input  NREQ*WIDTH  left denominators, same packing.
- req_r_num  input  NREQ*WIDTH  right numerators, same packing.
- req_r_den  input  NREQ*WIDTH  right denominators, same packing.
- resp_valid  output  1  result valid.
- resp_ready  input  1  consumer accepts result.
- resp_id  output  IDW  id of the requester that owns the result.
- resp_num  output  WIDTH  sum numerator.
- resp_den  output  WIDTH  sum denominator.
- resp_err  output  1  zero-denominator operand detected.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values:
  - State IDLE; round-robin pointer 0; all operand and temp registers 0.
  - resp_valid 0, resp_id 0, resp_num 0, resp_den 0, resp_err 0, busy 0, req_ready all 0 during the reset cycle.
  - rst overrides everything, including mid-operation: the in-flight operation is discarded and no response is produced.
- States: IDLE, CALC1, CALC2, RESP.
- IDLE:
  - Grant g = first i with req_valid[i] set, searching ptr, ptr+1, … modulo NREQ.
  - req_ready[g] is high combinationally, only in IDLE and only when rst is low.
  - On accept (req_valid[g] & req_ready[g]): latch the four operands of g, id <= g, ptr <= (g+1) mod NREQ, go to CALC1.
  - With no valid requests, stay in IDLE and leave ptr unchanged.
- CALC1:
  - If l_den==0 or r_den==0: resp_num<=0, resp_den<=0, resp_err<=1, go to RESP.
  - Else if l_den==r_den: resp_num<=l_num+r_num, resp_den<=l_den, resp_err<=0, go to RESP.
  - Else: t1<=l_num*r_den, t2<=r_num*l_den, t3<=l_den*r_den, go to CALC2.
- CALC2: resp_num<=t1+t2, resp_den<=t3, resp_err<=0, go to RESP.
- RESP:
  - resp_valid=1; resp_id/num/den/err held stable until resp_ready.
  - On resp_ready: go to IDLE; resp_valid drops the next cycle.
  - No new request is accepted in the same cycle as resp_ready; the earliest next accept is the following cycle.
- Arithmetic:
  - Unsigned, modulo 2^WIDTH.
  - Products keep the low WIDTH bits; sums wrap. No overflow flag.
  - No reduction by gcd.
- Latency: cycles from the accept edge to resp_valid high:
  - 1 for the equal-denominator or error path.
  - 2 for the cross-multiply path.
- Throughput: one operation per (latency + response wait + 1 IDLE cycle).
- Requester rules:
  - A requester may deassert req_valid before it is granted; no state changes.
  - Operands are sampled only on the accept edge; later input changes are ignored.
- busy = (state != IDLE).
- Outputs other than req_ready are registered.

Test Plan:
- Reset mid-CALC2: accept req0 {1/2 + 1/3}, assert rst in CALC2 -> no resp_valid; after reset busy=0, ptr=0; next lone req2 is granted.
- Equal denominators: req1 {3/8 + 4/8} accepted at edge E -> resp_valid high after E+1 with resp_num=7, resp_den=8, resp_id=1, resp_err=0.
- Cross-multiply: req0 {1/2 + 1/3} -> resp_valid after 2 cycles, resp_num=5, resp_den=6; hold resp_ready=0 for 4 cycles -> outputs stable, busy=1, all req_ready low.
- Round-robin: all four req_valid held high, each {1/1 + 1/1}, resp_ready=1 -> grant order 0,1,2,3,0; each resp_num=2, resp_den=1.
- Zero denominator: req3 {5/0 + 1/4} -> resp_err=1, resp_num=0, resp_den=0, latency 1, resp_id=3.
- Wrap-around arithmetic (WIDTH=8): {200/3 + 100/3} -> resp_num=44 (300 mod 256), resp_den=3; {16/17 + 1/16} -> num=(256+17) mod 256=17, den=(272) mod 256=16.
